// File: rtl/gen_emu_clks_ctrl.sv
// Emulator clock controller: divides emu_clk_2x by two into a gateable emu_clk,
// derives per-channel clocks that update on emu_clk rise, counts emulated
// cycles (saturating) and halts on stall or cycle-budget stop.
module gen_emu_clks_ctrl #(
    parameter int n         = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 emu_clk_2x,
    input  logic                 emu_rst,
    input  logic                 emu_stall,
    input  logic                 stop_en,
    input  logic [CNT_WIDTH-1:0] stop_cycle,
    input  logic [n-1:0]         clk_vals,
    input  logic [n-1:0]         clk_en,
    output logic                 emu_clk,
    output logic [n-1:0]         clks,
    output logic [CNT_WIDTH-1:0] emu_cycle_count,
    output logic                 halted
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t               state;
    logic                 ph;
    logic [n-1:0]         clks_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 hold;

    // Pause request: external stall or budget exhausted (unsigned compare).
    assign hold = emu_stall | (stop_en & (cnt >= stop_cycle));

    // Phase, channel clocks, cycle counter and run/halt state. A high phase
    // always completes; only reset may cut it short.
    always_ff @(posedge emu_clk_2x) begin
        if (emu_rst) begin
            ph     <= 1'b0;
            clks_q <= '0;
            cnt    <= '0;
            state  <= RUN;
        end else if (ph) begin
            ph <= 1'b0;
        end else if (!hold) begin
            ph     <= 1'b1;
            clks_q <= clk_vals & clk_en;
            if (cnt != {CNT_WIDTH{1'b1}})
                cnt <= cnt + 1'b1;
            state  <= RUN;
        end else begin
            state <= HALT;
        end
    end

    assign emu_cycle_count = cnt;
    assign halted          = (state == HALT);

`ifdef SIMULATION_MODE_MSDSL
    BUFG u_bufg_emu (.I(ph), .O(emu_clk));
    for (genvar k = 0; k < n; k++) begin : g_clk_buf
        BUFG u_bufg_ch (.I(clks_q[k]), .O(clks[k]));
    end
`else
    assign emu_clk = ph;
    assign clks    = clks_q;
`endif

endmodule

// File: tb/tb_gen_emu_clks_ctrl.sv
// Directed bench for gen_emu_clks_ctrl: main instance (n=3, 32-bit count) and a
// narrow-counter instance (n=1, CNT_WIDTH=2) for saturation.
module tb_gen_emu_clks_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, stop_en;
    logic [31:0] stop_cycle;
    logic [2:0]  vals, en;
    logic        emu_clk, halted;
    logic [2:0]  clks;
    logic [31:0] cnt;

    logic        rst2;
    logic        stall2 = 1'b0, stop_en2 = 1'b0;
    logic [1:0]  stop_cycle2 = 2'd0;
    logic [0:0]  vals2 = 1'b1, en2 = 1'b1;
    logic        emu_clk2, halted2;
    logic [0:0]  clks2;
    logic [1:0]  cnt2;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    gen_emu_clks_ctrl #(.n(3), .CNT_WIDTH(32)) dut (
        .emu_clk_2x(clk), .emu_rst(rst), .emu_stall(stall), .stop_en(stop_en),
        .stop_cycle(stop_cycle), .clk_vals(vals), .clk_en(en), .emu_clk(emu_clk),
        .clks(clks), .emu_cycle_count(cnt), .halted(halted));

    gen_emu_clks_ctrl #(.n(1), .CNT_WIDTH(2)) dut2 (
        .emu_clk_2x(clk), .emu_rst(rst2), .emu_stall(stall2), .stop_en(stop_en2),
        .stop_cycle(stop_cycle2), .clk_vals(vals2), .clk_en(en2), .emu_clk(emu_clk2),
        .clks(clks2), .emu_cycle_count(cnt2), .halted(halted2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one emu_clk_2x edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] last_vals;
        int pulses;
        logic prev;

        rst = 1; rst2 = 1; stall = 0; stop_en = 0; stop_cycle = 0;
        vals = 3'b000; en = 3'b111;
        tick(); tick();
        chk("rst_emu_clk", emu_clk, 0);
        chk("rst_clks", clks, 0);
        chk("rst_count", cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst2_count", cnt2, 0);

        // Free run with clk_vals changing every 2x cycle; first edge after
        // release is a rise. Channels only follow values sampled at rises.
        rst = 0;
        last_vals = 3'b000;
        for (int i = 0; i < 20; i++) begin
            vals = 3'((i * 5 + 3) % 8);
            if (i % 2 == 0) last_vals = vals;
            tick();
            chk("run_emu_clk", emu_clk, (i % 2 == 0) ? 1 : 0);
            chk("run_clks", clks, last_vals);
            chk("run_count", cnt, i / 2 + 1);
        end
        chk("run_count10", cnt, 10);

        // Disabled channel forced low while others follow.
        en = 3'b101; vals = 3'b111;
        tick();
        chk("en_clks", clks, 3'b101);
        chk("en_count", cnt, 11);

        // Stall during high phase: pulse completes, then halt.
        en = 3'b111; stall = 1;
        tick();
        chk("stall_fall", emu_clk, 0);
        chk("stall_not_yet", halted, 0);
        tick();
        chk("stall_halted", halted, 1);
        tick(); tick();
        chk("stall_clk_low", emu_clk, 0);
        chk("stall_count", cnt, 11);
        stall = 0;
        tick();
        chk("resume_clk", emu_clk, 1);
        chk("resume_halted", halted, 0);
        chk("resume_count", cnt, 12);
        chk("resume_clks", clks, 3'b111);
        tick();
        chk("resume_fall", emu_clk, 0);
        chk("resume_once", cnt, 12);

        // Reset during high phase truncates it.
        tick();
        chk("pre_rst_high", emu_clk, 1);
        rst = 1;
        tick();
        chk("midrst_clk", emu_clk, 0);
        chk("midrst_clks", clks, 0);
        chk("midrst_count", cnt, 0);
        chk("midrst_halted", halted, 0);

        // Reset while halted clears halted.
        rst = 0; stall = 1;
        tick();
        chk("halt_b4_rst", halted, 1);
        rst = 1;
        tick();
        chk("halt_rst", halted, 0);
        stall = 0;

        // Cycle budget of 5, then extend to 8.
        stop_en = 1; stop_cycle = 5; rst = 0;
        pulses = 0; prev = emu_clk;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (emu_clk && !prev) pulses++;
            prev = emu_clk;
        end
        chk("stop5_pulses", pulses, 5);
        chk("stop5_count", cnt, 5);
        chk("stop5_halted", halted, 1);
        chk("stop5_clk", emu_clk, 0);
        stop_cycle = 8;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (emu_clk && !prev) pulses++;
            prev = emu_clk;
        end
        chk("stop8_pulses", pulses, 3);
        chk("stop8_count", cnt, 8);
        chk("stop8_halted", halted, 1);

        // Budget 0 at release: halt immediately with no pulse.
        rst = 1; stop_cycle = 0;
        tick();
        rst = 0;
        tick();
        chk("zero_halted", halted, 1);
        chk("zero_clk", emu_clk, 0);
        chk("zero_count", cnt, 0);

        // Stall and stop together: dropping only the stop keeps halt.
        stall = 1; stop_en = 0;
        tick();
        chk("both_halted", halted, 1);
        chk("both_clk", emu_clk, 0);
        stall = 0;
        tick();
        chk("both_release", emu_clk, 1);
        chk("both_count", cnt, 1);

        // Narrow counter saturates at 3 while its clock keeps toggling.
        rst2 = 0;
        pulses = 0; prev = emu_clk2;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (emu_clk2 && !prev) pulses++;
            prev = emu_clk2;
        end
        chk("sat_pulses", pulses, 6);
        chk("sat_count", cnt2, 3);
        chk("sat_halted", halted2, 0);
        tick();
        chk("sat_still_running", emu_clk2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gen_emu_clks_ctrl.md
GEN_EMU_CLKS_CTRL -- requirements
Module: gen_emu_clks_ctrl

Interface
REQ-001 SHALL have parameter: n, 2, number of derived emulator clock channels (n >= 1).
REQ-002 SHALL have parameter: CNT_WIDTH, 32, width of emulated-cycle counter and stop threshold (2..64).
REQ-003 SHALL have port: emu_clk_2x  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port: emu_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: emu_stall  input  1  level request to pause emulation.
REQ-006 SHALL have port: stop_en  input  1  enables cycle-budget stop.
REQ-007 SHALL have port: stop_cycle  input  CNT_WIDTH  cycle budget; emulation halts once count reaches it.
REQ-008 SHALL have port: clk_vals  input  1 x [n]  requested next level of each channel clock.
REQ-009 SHALL have port: clk_en  input  1 x [n]  per-channel enable; disabled channel held low.
REQ-010 SHALL have port: emu_clk  output  1  emulator clock, emu_clk_2x divided by 2, gateable.
REQ-011 SHALL have port: clks  output  1 x [n]  derived channel clocks.
REQ-012 SHALL have port: emu_cycle_count  output  CNT_WIDTH  number of emu_clk rising edges since reset.
REQ-013 SHALL have port: halted  output  1  high while emu_clk is held low by stall or stop.

Function
REQ-014 SHALL keep a phase register ph driving emu_clk; no combinational path from any input to emu_clk, clks, halted.
REQ-015 SHALL define hold = emu_stall OR (stop_en AND emu_cycle_count >= stop_cycle), unsigned compare.
REQ-016 SHALL, on an edge with ph=1, set ph=0 unconditionally (high phase always completes; no runt pulses).
REQ-017 SHALL, on an edge with ph=0 and hold=0, set ph=1 (a "rise edge"); with ph=0 and hold=1, keep ph=0.
REQ-018 SHALL, on each rise edge only, load clks[k] <= clk_vals[k] AND clk_en[k] for every k; otherwise clks hold.
REQ-019 SHALL increment emu_cycle_count by 1 on each rise edge, saturating at 2^CNT_WIDTH-1 (no wrap); emu_clk keeps running at saturation.
REQ-020 SHALL implement two states: RUN (halted=0) and HALT (halted=1); RUN->HALT on an edge with ph=0 and hold=1; HALT->RUN on next rise edge; otherwise state holds.
REQ-021 SHALL, with hold permanently 0, produce emu_clk of period 2 emu_clk_2x cycles, 50% duty, and clks changes aligned to emu_clk rise (latency 1 emu_clk_2x edge from sampled clk_vals).
REQ-022 SHALL resume without skew: after HALT, first rise edge occurs on first edge where hold=0, count increments exactly once.
REQ-023 SHALL treat emu_stall and stop condition identically when simultaneous; release requires both deasserted.
REQ-024 SHALL allow stop_cycle/stop_en changes at any time; new value takes effect on next ph=0 edge; stop_cycle <= current count halts immediately at next ph=0 edge.
REQ-025 SHALL, when SIMULATION_MODE_MSDSL is defined, drive emu_clk and each clks[k] through a BUFG primitive; otherwise by direct assignment.

Reset
REQ-026 SHALL, on an edge with emu_rst=1, set ph=0, all clks=0, emu_cycle_count=0, state RUN (halted=0), overriding all other inputs.
REQ-027 SHALL, on reset mid-high-phase, force emu_clk low at that edge (reset is the only way to truncate a high phase).
REQ-028 SHALL, on first edge after emu_rst falls with hold=0, perform a rise edge (emu_cycle_count=1).
REQ-029 SHALL, with stop_en=1 and stop_cycle=0 at reset release, enter HALT on first edge with count 0 and no emu_clk pulse.

Verification
REQ-030 SHALL cover: n=3, reset, hold=0, clk_vals toggling each 2x cycle -> emu_clk period 2, clks update only at emu_clk rise, count=10 after 10 rises.
REQ-031 SHALL cover: emu_stall asserted while emu_clk=1 -> pulse completes, next edge halted=1, emu_clk stays 0, count frozen; deassert -> one rise on next edge, count+1.
REQ-032 SHALL cover: stop_en=1, stop_cycle=5 -> exactly 5 emu_clk pulses, halted=1, count=5; raise stop_cycle to 8 -> exactly 3 more pulses.
REQ-033 SHALL cover: clk_en[1]=0 with clk_vals[1]=1 -> clks[1]=0 while other channels follow clk_vals.
REQ-034 SHALL cover: CNT_WIDTH=2, stop_en=0, 6 rises -> count saturates at 3, emu_clk keeps toggling.
REQ-035 SHALL cover: emu_rst pulsed while emu_clk=1, halted=1 elsewhere -> next edge all outputs 0, count 0, halted 0.
